// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with overlapping or non-overlapping detection and a saturating match counter.
// The next state is the longest prefix of PATTERN that ends the accepted history.
module seq_detector_param #(
    parameter int                   PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1010,
    parameter int                   CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    localparam int                 SW      = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0]      MATCH_S = SW'(PAT_LEN);
    localparam logic [PAT_LEN-1:0] ONES    = '1;

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $fatal(1, "seq_detector_param: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
        $fatal(1, "seq_detector_param: CNT_W must be in 1..32");
    end

    logic [SW-1:0]      s;
    logic [SW-1:0]      s_restart;
    logic [SW-1:0]      ns;
    logic [PAT_LEN-2:0] hist;
    logic [PAT_LEN-1:0] win;

    // The last s bits of hist always equal the pattern prefix, so only the
    // newest s_restart+1 bits of the window may take part in a comparison.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        s_restart = (s == MATCH_S && !overlap) ? '0 : s;
        win       = {hist, x};
        ns        = '0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            if (k <= int'(s_restart) + 1 &&
                ((win ^ (PATTERN >> (PAT_LEN - k))) & (ONES >> (PAT_LEN - k))) == '0) begin
                ns = SW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s           <= '0;
            hist        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else if (in_valid) begin
            s    <= ns;
            hist <= win[PAT_LEN-2:0];
            z    <= (ns == MATCH_S);
            if (ns == MATCH_S && match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: two instances (1010/8-bit count and 111/2-bit count) share one stimulus
// stream; a suffix-search reference model predicts z and match_count after every edge.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst, x, in_valid, overlap;
    logic       z_a, z_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit za;
        int ca;
        bit zb;
        int cb;
    } exp_t;

    exp_t q[$];

    // Reference model state per instance: history since restart as a value/length pair.
    int pl[2]  = '{4, 3};
    int pat[2] = '{10, 7};
    int cm[2]  = '{255, 3};
    int ms[2], hv[2], hl[2], mc[2];

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
        .z(z_a), .match_count(cnt_a)
    );

    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
        .z(z_b), .match_count(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input int id, input bit r, input bit v, input bit b, input bit o);
        int mask;
        if (r) begin
            ms[id] = 0; hv[id] = 0; hl[id] = 0; mc[id] = 0;
        end else if (v) begin
            if (ms[id] == pl[id] && !o) begin
                hv[id] = 0; hl[id] = 0;
            end
            hv[id] = ((hv[id] << 1) | int'(b)) & ((1 << pl[id]) - 1);
            if (hl[id] < pl[id]) hl[id]++;
            ms[id] = 0;
            for (int k = 1; k <= hl[id]; k++) begin
                mask = (1 << k) - 1;
                if ((hv[id] & mask) == (pat[id] >> (pl[id] - k))) ms[id] = k;
            end
            if (ms[id] == pl[id] && mc[id] < cm[id]) mc[id]++;
        end
    endtask

    // Drive one cycle, update the model at the edge and queue the expected outputs.
    task automatic step(input bit r, input bit v, input bit b, input bit o);
        exp_t e;
        rst = r; in_valid = v; x = b; overlap = o;
        @(posedge clk);
        model_step(0, r, v, b, o);
        model_step(1, r, v, b, o);
        e.za = (ms[0] == pl[0]); e.ca = mc[0];
        e.zb = (ms[1] == pl[1]); e.cb = mc[1];
        q.push_back(e);
        #1;
    endtask

    task automatic bits(input string s, input bit o);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i] == "1", o);
    endtask

    // Monitor: outputs are compared on the falling edge against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("z_a", int'(z_a), int'(e.za));
            check("cnt_a", int'(cnt_a), e.ca);
            check("z_b", int'(z_b), int'(e.zb));
            check("cnt_b", int'(cnt_b), e.cb);
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = 1'b0; overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_z", int'(z_a), 0);
        check("reset_cnt", int'(cnt_a), 0);

        // Overlapping 101010: two matches.
        bits("101010", 1'b1);
        check("ovl_cnt", int'(cnt_a), 2);

        // Non-overlapping 101010, then 10 completes a second match.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits("101010", 1'b0);
        check("novl_cnt", int'(cnt_a), 1);
        check("novl_z_after6", int'(z_a), 0);
        bits("10", 1'b0);
        check("novl_cnt2", int'(cnt_a), 2);
        check("novl_z2", int'(z_a), 1);

        // Valid gaps freeze state.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        bits("11", 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
        bits("010", 1'b1);
        check("gap_z", int'(z_a), 1);
        check("gap_cnt", int'(cnt_a), 1);

        // Reset mid-pattern discards progress.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        bits("101", 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        bits("010", 1'b1);
        check("rst_mid_cnt", int'(cnt_a), 0);

        // Seven ones on the 111 instance: z stays high, count saturates at 3.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        bits("1111111", 1'b1);
        check("sat_z", int'(z_b), 1);
        check("sat_cnt", int'(cnt_b), 3);

        // Randomised stream with toggling valid, overlap and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Moore sequence detector for a single serial bit stream. It recognises an arbitrary `PAT_LEN`-bit pattern fixed at elaboration, selectable at runtime between overlapping and non-overlapping detection. It gates input with a valid qualifier and keeps a saturating match counter. It is the generalised successor to the fixed 4-bit detectors in the FSM library and drops into any serial front end that needs pattern flags.

## Interface
- `PAT_LEN`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1010: pattern value, `PAT_LEN` bits wide; `PATTERN[PAT_LEN-1]` is the first bit received.
- `CNT_W`, 8: width of the match counter; legal range 1..32.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `x`  input  1  serial data bit.
- `in_valid`  input  1  `x` is consumed on a rising edge only when `in_valid`=1.
- `overlap`  input  1  detection mode: 1 = overlapping, 0 = non-overlapping. Sampled together with each valid bit.
- `z`  output  1  Moore match flag: 1 while the FSM is in the MATCH state.
- `match_count`  output  `CNT_W`  number of matches since reset; saturates.

## Operation
- State `s` is an integer 0..`PAT_LEN`, encoded in ceil(log2(`PAT_LEN`+1)) bits.
  - `s` = length of the longest suffix of the bits accepted since the last restart point that equals a prefix of `PATTERN`.
  - `s`=`PAT_LEN` is the MATCH state.
- Next state on a valid bit `b`:
  - Let `s'` = `s`, except when `s`=`PAT_LEN` and `overlap`=0, in which case `s'` = 0. This is the non-overlap restart.
  - `ns` = largest `k` ≤ `s'`+1 such that the last `k` accepted bits (ending with `b`, counting only bits after the restart point) equal `PATTERN[PAT_LEN-1 -: k]`. If no such `k` exists, `ns` = 0.
- Overlap mode leaving MATCH: the next state uses the pattern's longest proper border. For 1010 the border is "10", so a following 1 gives `s`=3.
- Required implementation: the next-state function is computed per state from the parameters. Acceptable forms are a history shift register of `PAT_LEN`-1 bits with prefix comparators, or an elaborated failure table. Hand-coded per-pattern case statements are not acceptable.
- When `in_valid`=0, `s`, `z` and `match_count` hold.
- `z` = (`s` == `PAT_LEN`). It is decoded from registered state only and never depends combinationally on `x`, `in_valid` or `overlap`.
- `match_count` increments by 1 on each edge where `ns` = `PAT_LEN` and a valid bit is consumed.
  - At the all-ones value it holds; no wrap.
  - A MATCH→MATCH transition counts again. This is possible only in overlap mode with an all-identical pattern such as 1111.
- Changing `overlap` affects only the transition taken on the next valid bit. Accumulated state is not cleared.

## Timing
- Reset: when `rst`=1 at a rising edge, `s`=0, `z`=0 and `match_count`=0 on the following cycle. `rst` has priority over `in_valid`.
- Reset mid-pattern discards all partial progress. The first bit after reset is evaluated from `s`=0.
- Latency: the bit completing the pattern is accepted at edge N. `z`=1 and the updated `match_count` are visible from just after edge N until the next edge that consumes a valid bit (or applies reset).
- With `in_valid` held high, `z` is a one-cycle pulse per match. The exception is an all-identical pattern in overlap mode, where consecutive matches keep `z` high.
- Throughput: one bit per clock, with no back-pressure.
- Parameter legality (`PAT_LEN` out of range, `CNT_W` < 1) is checked at elaboration with a fatal error.

## Test plan
- Defaults, `overlap`=1, stream 1,0,1,0,1,0 (`in_valid`=1) -> `z` pulses after bits 4 and 6; `match_count`=2.
- Defaults, `overlap`=0, same stream -> `z` pulses after bit 4 only; final `s`=2; `match_count`=1. Then bits 1,0 -> second pulse; `match_count`=2.
- Defaults, stream 1,1,0,1,0 with `in_valid` low for 3 cycles between bits 2 and 3 -> single pulse after bit 5; `s` and `z` frozen during the gaps.
- Defaults, `rst` asserted after bits 1,0,1, then bits 0,1,0 -> no match; `z`=0 and `match_count`=0 throughout; `z` held 0 during reset.
- `PAT_LEN`=3, `PATTERN`=3'b111, `CNT_W`=2, `overlap`=1, seven consecutive 1s -> `z` high from bit 3 onward; `match_count` saturates at 3 and holds.
- Randomised long stream with `in_valid` and `overlap` toggling, against a reference-model scoreboard -> `z` and `match_count` match every cycle.
